// File: rtl/stack_pkg.sv
// Shared types and constants for the stack command sequencer and its helpers.
package stack_pkg;

    localparam int STACK_DEPTH = 5;
    localparam int STACK_WIDTH = 4;
    localparam int STACK_IDX_W = 3;

    // Stack COMMAND encoding as seen on the stack's command lines.
    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_t;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } seq_state_t;

    // Reduce a 3-bit index into the 0..4 range of a five-entry stack.
    function automatic logic [STACK_IDX_W-1:0] mod5(input logic [STACK_IDX_W-1:0] v);
        return (v >= 3'd5) ? (v - 3'd5) : v;
    endfunction

endpackage

// File: rtl/stack_occ_counter.sv
// Occupancy counter for the stack: counts 0..STACK_DEPTH, never wraps,
// and exposes full/empty flags decoded from the held count.
module stack_occ_counter
    import stack_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_clear,
    input  logic                   i_inc,
    input  logic                   i_dec,
    output logic [STACK_IDX_W-1:0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    logic [STACK_IDX_W-1:0] r_count;
    logic                   w_full;
    logic                   w_empty;

    assign w_full  = (r_count == 3'(STACK_DEPTH));
    assign w_empty = (r_count == 3'd0);

    // Count update: clear wins, then a saturating single-step inc or dec.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= 3'd0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_count <= r_count + 3'd1;
        end else if (i_dec && !i_inc && !w_empty) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Request/response front end for the 5-entry, 4-bit structural stack.
// Screens push/pop/get requests against the occupancy, issues each legal
// operation to the stack for exactly one cycle and returns the result.
// Optional build macro STACK_SEQ_ERRCNT_EN adds saturating overflow and
// underflow rejection counters (OVF_CNT, UNF_CNT).
module stack_cmd_sequencer
    import stack_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic [1:0]             REQ_CMD,
    input  logic [STACK_IDX_W-1:0] REQ_INDEX,
    input  logic [STACK_WIDTH-1:0] REQ_DATA,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [STACK_WIDTH-1:0] RSP_DATA,
    output logic                   RSP_ERR,
    output logic [STACK_IDX_W-1:0] COUNT,
    output logic [1:0]             STK_COMMAND,
    output logic [STACK_IDX_W-1:0] STK_INDEX,
    output logic [STACK_WIDTH-1:0] STK_WDATA,
    output logic                   STK_WDATA_OE,
    input  logic [STACK_WIDTH-1:0] STK_RDATA,
    output logic                   STK_RESET
`ifdef STACK_SEQ_ERRCNT_EN
    ,
    output logic [7:0]             OVF_CNT,
    output logic [7:0]             UNF_CNT
`endif
);

    seq_state_t             r_state;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [STACK_WIDTH-1:0] r_rsp_data;
    logic                   r_rsp_err;
    cmd_t                   r_stk_command;
    logic [STACK_IDX_W-1:0] r_stk_index;
    logic [STACK_WIDTH-1:0] r_stk_wdata;
    logic                   r_stk_wdata_oe;
    logic                   r_stk_reset;

    cmd_t                   w_cmd;
    logic [STACK_IDX_W-1:0] w_idx;
    logic [STACK_IDX_W-1:0] w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_ovf;
    logic                   w_unf;
    logic                   w_err;
    logic                   w_accept;
    logic                   w_inc;
    logic                   w_dec;

    assign w_cmd    = cmd_t'(REQ_CMD);
    assign w_idx    = mod5(REQ_INDEX);
    assign w_err    = w_ovf | w_unf;
    assign w_accept = REQ_VALID & r_req_ready;
    // Occupancy moves only on the edge that ends the one-cycle issue.
    assign w_inc    = (r_state == ISSUE) && (r_stk_command == CMD_PUSH);
    assign w_dec    = (r_state == ISSUE) && (r_stk_command == CMD_POP);

    stack_occ_counter u_occ (
        .i_clk   (CLK),
        .i_clear (RESET),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Classify the incoming request as overflow, underflow/out-of-range or legal.
    always_comb begin
        w_ovf = 1'b0;
        w_unf = 1'b0;
        case (w_cmd)
            CMD_PUSH: w_ovf = w_full;
            CMD_POP:  w_unf = w_empty;
            CMD_GET:  w_unf = (w_idx >= w_count);
            CMD_NOP:  w_unf = 1'b0;
            default: begin
                w_ovf = 1'b0;
                w_unf = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with all handshake and stack-facing outputs registered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= IDLE;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= 4'h0;
            r_rsp_err      <= 1'b0;
            r_stk_command  <= CMD_NOP;
            r_stk_index    <= 3'd0;
            r_stk_wdata    <= 4'h0;
            r_stk_wdata_oe <= 1'b0;
            r_stk_reset    <= 1'b1;
        end else begin
            // The stack stays in reset one cycle beyond our own reset.
            r_stk_reset <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (w_err || (w_cmd == CMD_NOP)) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_data  <= 4'h0;
                        end else begin
                            r_state        <= ISSUE;
                            r_stk_command  <= w_cmd;
                            r_stk_index    <= w_idx;
                            r_stk_wdata    <= REQ_DATA;
                            r_stk_wdata_oe <= (w_cmd == CMD_PUSH);
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_rsp_data     <= (r_stk_command == CMD_PUSH) ? 4'h0 : STK_RDATA;
                    r_rsp_err      <= 1'b0;
                    r_rsp_valid    <= 1'b1;
                    r_stk_command  <= CMD_NOP;
                    r_stk_wdata_oe <= 1'b0;
                    r_state        <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_req_ready    <= 1'b0;
                    r_rsp_valid    <= 1'b0;
                    r_stk_command  <= CMD_NOP;
                    r_stk_wdata_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef STACK_SEQ_ERRCNT_EN
    logic [7:0] r_ovf_cnt;
    logic [7:0] r_unf_cnt;

    // Saturating counts of rejected pushes and rejected pops/gets.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ovf_cnt <= 8'd0;
            r_unf_cnt <= 8'd0;
        end else begin
            if (w_accept && (r_state == IDLE) && w_ovf && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
            if (w_accept && (r_state == IDLE) && w_unf && (r_unf_cnt != 8'hFF)) begin
                r_unf_cnt <= r_unf_cnt + 8'd1;
            end
        end
    end

    assign OVF_CNT = r_ovf_cnt;
    assign UNF_CNT = r_unf_cnt;
`endif

    assign REQ_READY    = r_req_ready;
    assign RSP_VALID    = r_rsp_valid;
    assign RSP_DATA     = r_rsp_data;
    assign RSP_ERR      = r_rsp_err;
    assign COUNT        = w_count;
    assign STK_COMMAND  = r_stk_command;
    assign STK_INDEX    = r_stk_index;
    assign STK_WDATA    = r_stk_wdata;
    assign STK_WDATA_OE = r_stk_wdata_oe;
    assign STK_RESET    = r_stk_reset;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Self-checking bench for stack_cmd_sequencer: directed vector table,
// hand-written reset/backpressure sequences and randomized requests
// checked against a queue-based stack reference model.
module tb_stack_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_CMD = 2'b00;
    logic [2:0] REQ_INDEX = 3'd0;
    logic [3:0] REQ_DATA = 4'h0;
    logic       RSP_VALID;
    logic       RSP_READY = 1'b0;
    logic [3:0] RSP_DATA;
    logic       RSP_ERR;
    logic [2:0] COUNT;
    logic [1:0] STK_COMMAND;
    logic [2:0] STK_INDEX;
    logic [3:0] STK_WDATA;
    logic       STK_WDATA_OE;
    logic [3:0] STK_RDATA;
    logic       STK_RESET;
`ifdef STACK_SEQ_ERRCNT_EN
    logic [7:0] OVF_CNT;
    logic [7:0] UNF_CNT;
`endif

    int checks = 0;
    int errors = 0;

    stack_cmd_sequencer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_CMD      (REQ_CMD),
        .REQ_INDEX    (REQ_INDEX),
        .REQ_DATA     (REQ_DATA),
        .RSP_VALID    (RSP_VALID),
        .RSP_READY    (RSP_READY),
        .RSP_DATA     (RSP_DATA),
        .RSP_ERR      (RSP_ERR),
        .COUNT        (COUNT),
        .STK_COMMAND  (STK_COMMAND),
        .STK_INDEX    (STK_INDEX),
        .STK_WDATA    (STK_WDATA),
        .STK_WDATA_OE (STK_WDATA_OE),
        .STK_RDATA    (STK_RDATA),
        .STK_RESET    (STK_RESET)
`ifdef STACK_SEQ_ERRCNT_EN
        ,
        .OVF_CNT      (OVF_CNT),
        .UNF_CNT      (UNF_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural stand-in for the structural stack, driven by the DUT's stack lines.
    logic [3:0] emu_mem [0:7];
    int         emu_cnt = 0;

    always @(posedge CLK) begin
        if (STK_RESET) begin
            emu_cnt <= 0;
        end else begin
            case (STK_COMMAND)
                2'b01: if (emu_cnt < 8) begin
                    emu_mem[emu_cnt] <= STK_WDATA;
                    emu_cnt <= emu_cnt + 1;
                end
                2'b10: if (emu_cnt > 0) emu_cnt <= emu_cnt - 1;
                default: ;
            endcase
        end
    end

    always_comb begin
        STK_RDATA = 4'h0;
        if (STK_COMMAND == 2'b10 && emu_cnt > 0)
            STK_RDATA = emu_mem[emu_cnt-1];
        else if (STK_COMMAND == 2'b11 && int'(STK_INDEX) < emu_cnt)
            STK_RDATA = emu_mem[emu_cnt-1-int'(STK_INDEX)];
    end

    // Continuous protocol watch: single-cycle commands, OE only with push, bounded count.
    logic [1:0] prev_cmd = 2'b00;
    always @(negedge CLK) begin
        if (!RESET) begin
            if (STK_COMMAND != 2'b00) check("cmd_single_cycle", int'(prev_cmd), 0);
            check("wdata_oe", int'(STK_WDATA_OE), int'(STK_COMMAND == 2'b01));
            check("count_max", int'(COUNT <= 3'd5), 1);
        end
        prev_cmd <= STK_COMMAND;
    end

    // Reference model: stack as a queue, back = top of stack.
    logic [3:0] ref_q[$];
    int ref_ovf = 0;
    int ref_unf = 0;

    task automatic model_step(input logic [1:0] c, input logic [2:0] i, input logic [3:0] d,
                              output logic e, output logic [3:0] rd);
        int i5 = int'(i) % 5;
        int n  = ref_q.size();
        e  = 1'b0;
        rd = 4'h0;
        case (c)
            2'b01: if (n == 5) begin e = 1'b1; if (ref_ovf < 255) ref_ovf++; end
                   else ref_q.push_back(d);
            2'b10: if (n == 0) begin e = 1'b1; if (ref_unf < 255) ref_unf++; end
                   else rd = ref_q.pop_back();
            2'b11: if (i5 >= n) begin e = 1'b1; if (ref_unf < 255) ref_unf++; end
                   else rd = ref_q[n-1-i5];
            default: ;
        endcase
    endtask

    // One complete request/response transaction; called just after a rising edge.
    task automatic run_req(input string tag, input logic [1:0] c, input logic [2:0] i,
                           input logic [3:0] d, input int delay, input logic exp_err,
                           input logic [3:0] exp_data, input int exp_count);
        bit got = 1'b0;
        int lat = 0;
        int ncmd = 0;
        logic [1:0] s_cmd = 2'b00;
        logic [2:0] s_idx = 3'd0;
        logic [3:0] s_wd = 4'h0;
        bit legal = !exp_err && (c != 2'b00);
        REQ_VALID = 1'b1;
        REQ_CMD   = c;
        REQ_INDEX = i;
        REQ_DATA  = d;
        RSP_READY = (delay == 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (REQ_READY) begin got = 1'b1; break; end
        end
        check({tag, "_accept"}, int'(got), 1);
        if (!got) begin REQ_VALID = 1'b0; RSP_READY = 1'b0; return; end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        REQ_CMD   = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            lat++;
            if (STK_COMMAND != 2'b00) begin
                ncmd++;
                s_cmd = STK_COMMAND;
                s_idx = STK_INDEX;
                s_wd  = STK_WDATA;
            end
            if (RSP_VALID) begin got = 1'b1; break; end
        end
        check({tag, "_rsp_valid"}, int'(got), 1);
        if (!got) begin RSP_READY = 1'b0; return; end
        check({tag, "_latency"}, lat, legal ? 2 : 1);
        check({tag, "_ncmd"}, ncmd, legal ? 1 : 0);
        if (legal) begin
            check({tag, "_stk_cmd"}, int'(s_cmd), int'(c));
            check({tag, "_stk_idx"}, int'(s_idx), int'(i) % 5);
            if (c == 2'b01) check({tag, "_stk_wdata"}, int'(s_wd), int'(d));
        end
        check({tag, "_err"}, int'(RSP_ERR), int'(exp_err));
        check({tag, "_data"}, int'(RSP_DATA), int'(exp_data));
        check({tag, "_count"}, int'(COUNT), exp_count);
        check({tag, "_req_ready_resp"}, int'(REQ_READY), 0);
        for (int j = 0; j < delay; j++) begin
            @(negedge CLK);
            check({tag, "_hold_valid"}, int'(RSP_VALID), 1);
            check({tag, "_hold_data"}, int'(RSP_DATA), int'(exp_data));
            check({tag, "_hold_err"}, int'(RSP_ERR), int'(exp_err));
            check({tag, "_hold_ready"}, int'(REQ_READY), 0);
            check({tag, "_hold_count"}, int'(COUNT), exp_count);
        end
        if (delay > 0) RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        check({tag, "_valid_drop"}, int'(RSP_VALID), 0);
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [2:0] idx;
        logic [3:0] data;
        int         delay;
        logic       err;
        logic [3:0] rdata;
        int         cnt;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic       m_err;
        logic [3:0] m_data;
        vecs[0]  = '{2'b01, 3'd0, 4'h3, 0, 1'b0, 4'h0, 1};
        vecs[1]  = '{2'b01, 3'd0, 4'h7, 0, 1'b0, 4'h0, 2};
        vecs[2]  = '{2'b01, 3'd0, 4'hA, 0, 1'b0, 4'h0, 3};
        vecs[3]  = '{2'b11, 3'd1, 4'h0, 0, 1'b0, 4'h7, 3};
        vecs[4]  = '{2'b01, 3'd0, 4'h1, 0, 1'b0, 4'h0, 4};
        vecs[5]  = '{2'b01, 3'd0, 4'h2, 1, 1'b0, 4'h0, 5};
        vecs[6]  = '{2'b01, 3'd0, 4'h4, 0, 1'b1, 4'h0, 5};
        vecs[7]  = '{2'b10, 3'd0, 4'h0, 0, 1'b0, 4'h2, 4};
        vecs[8]  = '{2'b11, 3'd6, 4'h0, 0, 1'b0, 4'hA, 4};
        vecs[9]  = '{2'b00, 3'd0, 4'h5, 0, 1'b0, 4'h0, 4};
        vecs[10] = '{2'b10, 3'd0, 4'h0, 4, 1'b0, 4'h1, 3};
        vecs[11] = '{2'b10, 3'd0, 4'h0, 0, 1'b0, 4'hA, 2};
        vecs[12] = '{2'b11, 3'd2, 4'h0, 0, 1'b1, 4'h0, 2};
        vecs[13] = '{2'b11, 3'd6, 4'h0, 2, 1'b0, 4'h3, 2};
        vecs[14] = '{2'b10, 3'd0, 4'h0, 0, 1'b0, 4'h7, 1};
        vecs[15] = '{2'b10, 3'd0, 4'h0, 0, 1'b0, 4'h3, 0};
        vecs[16] = '{2'b10, 3'd0, 4'h0, 0, 1'b1, 4'h0, 0};
        vecs[17] = '{2'b11, 3'd0, 4'h0, 0, 1'b1, 4'h0, 0};

        // Reset state.
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_count", int'(COUNT), 0);
        check("rst_rsp_valid", int'(RSP_VALID), 0);
        check("rst_rsp_data", int'(RSP_DATA), 0);
        check("rst_rsp_err", int'(RSP_ERR), 0);
        check("rst_stk_cmd", int'(STK_COMMAND), 0);
        check("rst_stk_idx", int'(STK_INDEX), 0);
        check("rst_stk_wdata", int'(STK_WDATA), 0);
        check("rst_stk_oe", int'(STK_WDATA_OE), 0);
        check("rst_stk_reset", int'(STK_RESET), 1);
        check("rst_req_ready", int'(REQ_READY), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rel_stk_reset_hold", int'(STK_RESET), 1);
        check("rel_req_ready_low", int'(REQ_READY), 0);
        @(negedge CLK);
        check("rel_stk_reset_clear", int'(STK_RESET), 0);
        check("rel_req_ready_high", int'(REQ_READY), 1);
        check("rel_count", int'(COUNT), 0);
        check("rel_rsp_valid", int'(RSP_VALID), 0);
        @(posedge CLK); #1;

        // Directed vector table.
        for (int v = 0; v < 18; v++) begin
            model_step(vecs[v].cmd, vecs[v].idx, vecs[v].data, m_err, m_data);
            run_req($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].idx, vecs[v].data,
                    vecs[v].delay, vecs[v].err, vecs[v].rdata, vecs[v].cnt);
        end
`ifdef STACK_SEQ_ERRCNT_EN
        check("vec_ovf_cnt", int'(OVF_CNT), 1);
        check("vec_unf_cnt", int'(UNF_CNT), 3);
`endif

        // Reset asserted while a pop is being issued.
        model_step(2'b01, 3'd0, 4'h5, m_err, m_data);
        run_req("mr_push0", 2'b01, 3'd0, 4'h5, 0, m_err, m_data, ref_q.size());
        model_step(2'b01, 3'd0, 4'h9, m_err, m_data);
        run_req("mr_push1", 2'b01, 3'd0, 4'h9, 0, m_err, m_data, ref_q.size());
        REQ_VALID = 1'b1;
        REQ_CMD   = 2'b10;
        RSP_READY = 1'b1;
        begin
            bit got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge CLK);
                if (REQ_READY) begin got = 1'b1; break; end
            end
            check("mr_accept", int'(got), 1);
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        REQ_CMD   = 2'b00;
        check("mr_issue_cmd", int'(STK_COMMAND), 2);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("mr_rsp_valid", int'(RSP_VALID), 0);
        check("mr_count", int'(COUNT), 0);
        check("mr_stk_reset_on", int'(STK_RESET), 1);
        check("mr_stk_cmd", int'(STK_COMMAND), 0);
        check("mr_req_ready_low", int'(REQ_READY), 0);
        @(negedge CLK);
        check("mr_stk_reset_off", int'(STK_RESET), 0);
        check("mr_no_response", int'(RSP_VALID), 0);
        check("mr_req_ready_high", int'(REQ_READY), 1);
        RSP_READY = 1'b0;
        ref_q.delete();
        ref_ovf = 0;
        ref_unf = 0;
        @(posedge CLK); #1;
        model_step(2'b10, 3'd0, 4'h0, m_err, m_data);
        run_req("mr_pop_empty", 2'b10, 3'd0, 4'h0, 0, m_err, m_data, ref_q.size());

        // Randomized requests against the reference model.
        for (int r = 0; r < 60; r++) begin
            int         sel = $urandom_range(0, 9);
            logic [1:0] c;
            logic [2:0] i = 3'($urandom_range(0, 7));
            logic [3:0] d = 4'($urandom_range(0, 15));
            int         dl = $urandom_range(0, 2);
            if (sel < 4)       c = 2'b01;
            else if (sel < 6)  c = 2'b10;
            else if (sel < 9)  c = 2'b11;
            else               c = 2'b00;
            model_step(c, i, d, m_err, m_data);
            run_req($sformatf("rnd%0d", r), c, i, d, dl, m_err, m_data, ref_q.size());
        end
`ifdef STACK_SEQ_ERRCNT_EN
        check("rnd_ovf_cnt", int'(OVF_CNT), ref_ovf);
        check("rnd_unf_cnt", int'(UNF_CNT), ref_unf);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
